led_pattern_seq: RTL

// - Downstream consumer of the blink counter's wrap pulse (flg): turns each wrap tick into
//   a multi-LED pattern step (blink / chase / bounce).
// - Mode changes arrive over a valid/ready handshake and take effect only on a step boundary.
// - Optional PWM dimming stage on the LED outputs.

---
 rtl/led_pattern_seq_if.sv | 10 +
 rtl/led_pattern_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/led_pattern_seq_if.sv
// Mode-change handshake between a mode source (master) and led_pattern_seq (slave).
// The transfer happens on a cycle where mode_valid and mode_ready are both high.
interface led_pattern_seq_if;
   logic [1:0] mode_in;
   logic       mode_valid;
   logic       mode_ready;

   modport master (output mode_in, output mode_valid, input mode_ready);
   modport slave  (input mode_in, input mode_valid, output mode_ready);
endinterface

// File: rtl/led_pattern_seq.sv
// Turns blink-counter wrap ticks into blink/chase/bounce LED pattern steps.
// Define LED_SEQ_PWM_EN to add a duty-cycle dimming stage on the LED outputs.
module led_pattern_seq #(
   parameter int NLED       = 4,
   parameter int STEP_TICKS = 2,
   parameter int PWM_BITS   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick_in,
   input  logic [PWM_BITS-1:0] duty_in,
   led_pattern_seq_if.slave    mbus,
   output logic [NLED-1:0]     leds,
   output logic                step_pulse
);

   localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam logic [TW-1:0]   LAST_TICK = TW'(STEP_TICKS - 1);
   localparam logic [NLED-1:0] ONE_HOT0  = NLED'(1);

   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_BLINK  = 2'd1;
   localparam logic [1:0] MODE_CHASE  = 2'd2;
   localparam logic [1:0] MODE_BOUNCE = 2'd3;

   logic [TW-1:0]   tickCnt;
   logic [1:0]      mode;
   logic [1:0]      pendMode;
   logic            pending;
   logic            dirDown;
   logic [NLED-1:0] pattern;
   logic [NLED-1:0] nextPattern;
   logic            nextDirDown;
   logic            step;
   logic            accept;

   assign step            = tick_in && (tickCnt == LAST_TICK);
   assign accept          = mbus.mode_valid && !pending;
   assign mbus.mode_ready = !pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tickCnt <= '0;
      end else if (tick_in) begin
         tickCnt <= step ? '0 : tickCnt + TW'(1);
      end
   end

   // A pending mode always wins over advancing: the step loads its initial pattern.
   always_comb begin
      nextPattern = pattern;
      nextDirDown = dirDown;
      if (pending) begin
         nextDirDown = 1'b0;
         case (pendMode)
            MODE_BLINK:  nextPattern = '1;
            MODE_CHASE:  nextPattern = ONE_HOT0;
            MODE_BOUNCE: nextPattern = ONE_HOT0;
            default:     nextPattern = '0;
         endcase
      end else begin
         case (mode)
            MODE_BLINK: nextPattern = ~pattern;
            MODE_CHASE: nextPattern = (pattern << 1) | (pattern >> (NLED - 1));
            MODE_BOUNCE: begin
               if (NLED == 1) begin
                  nextPattern = ONE_HOT0;
               end else if (!dirDown) begin
                  nextPattern = pattern << 1;
                  nextDirDown = nextPattern[NLED-1];
               end else begin
                  nextPattern = pattern >> 1;
                  nextDirDown = !nextPattern[0];
               end
            end
            default: nextPattern = '0;
         endcase
      end
   end

   // An acceptance coinciding with a step sees pending==0, so that step advances normally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode       <= MODE_OFF;
         pendMode   <= MODE_OFF;
         pending    <= 1'b0;
         dirDown    <= 1'b0;
         pattern    <= '0;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= step;
         if (step) begin
            pattern <= nextPattern;
            dirDown <= nextDirDown;
            if (pending) begin
               mode <= pendMode;
            end
         end
         if (accept) begin
            pendMode <= mbus.mode_in;
            pending  <= 1'b1;
         end else if (step) begin
            pending <= 1'b0;
         end
      end
   end

`ifdef LED_SEQ_PWM_EN
   logic [PWM_BITS-1:0] pwmCnt;
   logic                pwmOn;

   // Full-scale duty bypasses the compare so the LEDs stay continuously lit.
   assign pwmOn = (duty_in == '1) || (pwmCnt < duty_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwmCnt <= '0;
         leds   <= '0;
      end else begin
         pwmCnt <= pwmCnt + PWM_BITS'(1);
         leds   <= pattern & {NLED{pwmOn}};
      end
   end
`else
   logic unusedDuty;
   assign unusedDuty = ^duty_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leds <= '0;
      end else begin
         leds <= pattern;
      end
   end
`endif

endmodule
